// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: address decoder and bus controller between the CPU external
// bus and the memory devices (boot ROM, WRAM, cartridge port). Also holds the
// boot-ROM-disable latch at 0xFF50 and the internal HRAM at 0xFF80 upward.
//
// Optional feature macro: MEM_ECHO_EN
//   defined   -> 0xE000-0xFDFF mirrors WRAM (read and write)
//   undefined -> 0xE000-0xFDFF is unmapped
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cpu_addr/cpu_dout     CPU address and write data
//   cpu_din, rd_valid     registered read data and its one-cycle valid pulse
//   mem_oe/mem_wr/mem_cs  CPU read strobe, write strobe, bus-cycle qualifier
//   boot_oe/boot_addr     boot ROM enable and address; boot_dout read data
//   wram_*                WRAM select, read/write enables, address, data
//   cart_cs/cart_dout     cartridge select and read data
//   boot_done             boot ROM disabled (sticky latch)
module mem_bus_ctrl #(
  parameter int unsigned HRAM_DEPTH   = 127,
  parameter logic [7:0]  UNMAPPED_VAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        mem_oe,
  input  logic        mem_wr,
  input  logic        mem_cs,
  output logic        rd_valid,
  output logic        boot_oe,
  output logic [7:0]  boot_addr,
  input  logic [7:0]  boot_dout,
  output logic        wram_cs,
  output logic        wram_oe,
  output logic        wram_wr,
  output logic [12:0] wram_addr,
  output logic [7:0]  wram_din,
  input  logic [7:0]  wram_dout,
  output logic        cart_cs,
  input  logic [7:0]  cart_dout,
  output logic        boot_done
);

  localparam int unsigned HIW = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;

  typedef enum logic [2:0] {
    DEV_NONE,
    DEV_BOOT,
    DEV_CART,
    DEV_WRAM,
    DEV_LATCH,
    DEV_HRAM
  } dev_e;

  dev_e           dev;
  logic           rd_req;
  logic           wr_req;
  logic [15:0]    hram_off;
  logic [HIW-1:0] hram_idx;
  logic [7:0]     rd_data;
  logic [7:0]     hram [HRAM_DEPTH];

  // A simultaneous read+write strobe is treated as a write only; reset
  // suppresses every access in its cycle.
  assign rd_req   = ~rst & mem_cs & mem_oe & ~mem_wr;
  assign wr_req   = ~rst & mem_cs & mem_wr;
  assign hram_off = cpu_addr - 16'hFF80;
  assign hram_idx = hram_off[HIW-1:0];

  always_comb begin
    dev = DEV_NONE;
    if (!boot_done && cpu_addr[15:8] == 8'h00)      dev = DEV_BOOT;
    else if (!cpu_addr[15])                         dev = DEV_CART;
    else if (cpu_addr[15:13] == 3'b101)             dev = DEV_CART;
    else if (cpu_addr[15:13] == 3'b110)             dev = DEV_WRAM;
`ifdef MEM_ECHO_EN
    else if (cpu_addr[15:13] == 3'b111 && cpu_addr < 16'hFE00) dev = DEV_WRAM;
`endif
    else if (cpu_addr == 16'hFF50)                  dev = DEV_LATCH;
    else if (cpu_addr >= 16'hFF80 && hram_off < 16'(HRAM_DEPTH)) dev = DEV_HRAM;
  end

  assign boot_oe   = rd_req && dev == DEV_BOOT;
  assign cart_cs   = (rd_req || wr_req) && dev == DEV_CART;
  assign wram_cs   = (rd_req || wr_req) && dev == DEV_WRAM;
  assign wram_oe   = rd_req && dev == DEV_WRAM;
  assign wram_wr   = wr_req && dev == DEV_WRAM;
  assign boot_addr = cpu_addr[7:0];
  assign wram_addr = cpu_addr[12:0];
  assign wram_din  = cpu_dout;

  always_comb begin
    rd_data = UNMAPPED_VAL;
    case (dev)
      DEV_BOOT:  rd_data = boot_dout;
      DEV_CART:  rd_data = cart_dout;
      DEV_WRAM:  rd_data = wram_dout;
      DEV_LATCH: rd_data = {7'h7F, boot_done};
      DEV_HRAM:  rd_data = hram[hram_idx];
      default:   rd_data = UNMAPPED_VAL;
    endcase
  end

  // HRAM contents survive reset; asynchronous read gives write-then-read
  // in consecutive cycles the new value.
  always_ff @(posedge clk) begin
    if (wr_req && dev == DEV_HRAM) hram[hram_idx] <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_din   <= '0;
      rd_valid  <= 1'b0;
      boot_done <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) cpu_din <= rd_data;
      if (wr_req && dev == DEV_LATCH && cpu_dout[0]) boot_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
module tb_mem_bus_ctrl;
  localparam int HD = 127;
  localparam int R_NONE = 0, R_BOOT = 1, R_CART = 2, R_WRAM = 3, R_LATCH = 4, R_HRAM = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        mem_oe = 1'b0, mem_wr = 1'b0, mem_cs = 1'b0;
  logic        rd_valid, boot_oe, wram_cs, wram_oe, wram_wr, cart_cs, boot_done;
  logic [7:0]  boot_addr, wram_din;
  logic [12:0] wram_addr;
  logic [7:0]  boot_dout = '0, wram_dout = '0, cart_dout = '0;

  mem_bus_ctrl #(.HRAM_DEPTH(HD), .UNMAPPED_VAL(8'hFF)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .mem_oe(mem_oe), .mem_wr(mem_wr), .mem_cs(mem_cs),
    .rd_valid(rd_valid), .boot_oe(boot_oe), .boot_addr(boot_addr),
    .boot_dout(boot_dout), .wram_cs(wram_cs), .wram_oe(wram_oe),
    .wram_wr(wram_wr), .wram_addr(wram_addr), .wram_din(wram_din),
    .wram_dout(wram_dout), .cart_cs(cart_cs), .cart_dout(cart_dout),
    .boot_done(boot_done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory map expressed as address ranges.
  function automatic int region(input logic [15:0] a, input logic bd);
    int unsigned v;
    v = a;
    if (v < 32'h100 && !bd) return R_BOOT;
    if (v < 32'h8000 || (v >= 32'hA000 && v < 32'hC000)) return R_CART;
    if (v >= 32'hC000 && v < 32'hE000) return R_WRAM;
`ifdef MEM_ECHO_EN
    if (v >= 32'hE000 && v < 32'hFE00) return R_WRAM;
`endif
    if (v == 32'hFF50) return R_LATCH;
    if (v >= 32'hFF80 && v < 32'hFF80 + HD) return R_HRAM;
    return R_NONE;
  endfunction

  // Behavioural model state
  bit         started = 0;
  logic       m_bd = 1'b0;
  logic [7:0] m_din = '0;
  bit         m_din_known = 0;
  logic       m_rv = 1'b0;
  logic [7:0] m_hram [HD];
  bit         m_hk [HD];

  always @(posedge clk) begin
    int r;
    int idx;
    logic rd, wr;
    if (rst) begin
      started = 1; m_bd = 1'b0; m_din = 8'h00; m_din_known = 1; m_rv = 1'b0;
    end else begin
      rd  = mem_cs & mem_oe & ~mem_wr;
      wr  = mem_cs & mem_wr;
      r   = region(cpu_addr, m_bd);
      idx = int'(cpu_addr) - 32'hFF80;
      m_rv = rd;
      if (rd) begin
        m_din_known = 1;
        case (r)
          R_BOOT:  m_din = boot_dout;
          R_CART:  m_din = cart_dout;
          R_WRAM:  m_din = wram_dout;
          R_LATCH: m_din = m_bd ? 8'hFF : 8'hFE;
          R_HRAM:  begin m_din = m_hram[idx]; m_din_known = m_hk[idx]; end
          default: m_din = 8'hFF;
        endcase
      end
      if (wr) begin
        if (r == R_LATCH && cpu_dout[0]) m_bd = 1'b1;
        if (r == R_HRAM) begin m_hram[idx] = cpu_dout; m_hk[idx] = 1; end
      end
    end
  end

  always @(negedge clk) begin
    int r;
    logic rd, acc;
    logic [4:0] e;
    if (started) begin
      chk("rd_valid", rd_valid, m_rv);
      if (m_din_known) chk("cpu_din", cpu_din, m_din);
      chk("boot_done", boot_done, m_bd);
      rd  = ~rst & mem_cs & mem_oe & ~mem_wr;
      acc = ~rst & mem_cs & (mem_oe | mem_wr);
      r   = region(cpu_addr, m_bd);
      e   = {rd && r == R_BOOT, acc && r == R_CART, acc && r == R_WRAM,
             rd && r == R_WRAM, (acc && mem_wr) && r == R_WRAM};
      chk("enables", {boot_oe, cart_cs, wram_cs, wram_oe, wram_wr}, e);
      if (e[2]) begin
        chk("wram_addr", wram_addr, cpu_addr % 16'h2000);
        chk("wram_din", wram_din, cpu_dout);
      end
      if (e[4]) chk("boot_addr", boot_addr, cpu_addr % 16'h100);
    end
  end

  task automatic go(input logic [15:0] a, input logic oe, input logic wr,
                    input logic [7:0] d, input logic cs = 1'b1, input logic r = 1'b0);
    @(posedge clk); #1;
    rst = r; cpu_addr = a; mem_oe = oe; mem_wr = wr; cpu_dout = d; mem_cs = cs;
    @(negedge clk);
  endtask

  task automatic idle();
    go(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    go(16'h0000, 0, 0, 8'h00, 0, 1);
    go(16'h0000, 0, 0, 8'h00, 0, 1);
    chk("rst_cpu_din", cpu_din, 16'h00);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_enables", {boot_oe, cart_cs, wram_cs, wram_oe, wram_wr}, 0);

    // 1: boot ROM read
    boot_dout = 8'h31; cart_dout = 8'hC3;
    go(16'h0000, 1, 0, 8'h00);
    chk("t1_boot_oe", boot_oe, 1);
    chk("t1_cart_cs", cart_cs, 0);
    idle();
    chk("t1_cpu_din", cpu_din, 16'h31);
    chk("t1_rd_valid", rd_valid, 1);
    idle();
    chk("t1_rd_valid_drop", rd_valid, 0);
    chk("t1_din_hold", cpu_din, 16'h31);

    // Latch write with bit0 clear does nothing
    go(16'hFF50, 0, 1, 8'hFE);
    go(16'hFF50, 1, 0, 8'h00);
    idle();
    chk("latch_bit0_clear", cpu_din, 16'hFE);

    // 2: boot handover
    go(16'hFF50, 0, 1, 8'h01);
    go(16'h0000, 1, 0, 8'h00);
    chk("t2_boot_done", boot_done, 1);
    chk("t2_cart_cs", cart_cs, 1);
    chk("t2_boot_oe", boot_oe, 0);
    go(16'hFF50, 1, 0, 8'h00);
    chk("t2_cpu_din", cpu_din, 16'hC3);
    idle();
    chk("t2_latch_read", cpu_din, 16'hFF);

    // Cartridge boundaries, unmapped 0x8000, strobe with cs low
    cart_dout = 8'h3C;
    go(16'h7FFF, 1, 0, 8'h00); chk("cart_7fff", cart_cs, 1);
    go(16'h8000, 1, 0, 8'h00); chk("vram_unmapped", cart_cs, 0);
    go(16'hBFFF, 1, 0, 8'h00); chk("cart_bfff", cart_cs, 1);
    chk("unmapped_8000_din", cpu_din, 16'hFF);
    go(16'hA000, 0, 1, 8'h12, 0); chk("cs_low_no_enable", cart_cs, 0);
    chk("cart_bfff_din", cpu_din, 16'h3C);
    idle();
    chk("cs_low_no_read", rd_valid, 0);

    // 3: WRAM and echo
    go(16'hC123, 0, 1, 8'hA5);
    chk("t3_wram_cs", wram_cs, 1);
    chk("t3_wram_wr", wram_wr, 1);
    chk("t3_wram_addr", wram_addr, 16'h0123);
    chk("t3_wram_din", wram_din, 16'hA5);
    wram_dout = 8'hA5;
    go(16'hE123, 1, 0, 8'h00);
`ifdef MEM_ECHO_EN
    chk("t3_echo_cs", wram_cs, 1);
    chk("t3_echo_addr", wram_addr, 16'h0123);
    idle();
    chk("t3_echo_din", cpu_din, 16'hA5);
`else
    chk("t3_echo_cs", wram_cs, 0);
    idle();
    chk("t3_echo_din", cpu_din, 16'hFF);
`endif
    go(16'hC123, 1, 0, 8'h00);
    chk("t3_wram_oe", wram_oe, 1);
    idle();
    chk("t3_wram_din_rd", cpu_din, 16'hA5);

    // 4: HRAM write then immediate read, unmapped reads
    go(16'hFFFE, 0, 1, 8'h5A);
    go(16'hFFFE, 1, 0, 8'h00);
    go(16'hFEA0, 1, 0, 8'h00);
    chk("t4_hram_din", cpu_din, 16'h5A);
    chk("t4_unmapped_enables", {boot_oe, cart_cs, wram_cs, wram_oe, wram_wr}, 0);
    go(16'hFFFF, 1, 0, 8'h00);
    chk("t4_unmapped_din", cpu_din, 16'hFF);
    go(16'hFFFF, 0, 1, 8'h00);
    chk("t4_ffff_din", cpu_din, 16'hFF);
    go(16'hFFFE, 1, 0, 8'h00);
    idle();
    chk("t4_ffff_write_dropped", cpu_din, 16'h5A);

    // 5: simultaneous read+write
    go(16'hFF80, 1, 1, 8'h77);
    idle();
    chk("t5_rd_valid", rd_valid, 0);
    go(16'hFF80, 1, 0, 8'h00);
    idle();
    chk("t5_hram0", cpu_din, 16'h77);

    // 6: reset during a write
    go(16'hFF81, 0, 1, 8'h11);
    go(16'hFF81, 0, 1, 8'h99, 1, 1);
    idle();
    chk("t6_boot_done", boot_done, 0);
    chk("t6_cpu_din", cpu_din, 16'h00);
    go(16'hFF81, 1, 0, 8'h00);
    idle();
    chk("t6_hram1", cpu_din, 16'h11);

    // Reset during a read
    go(16'hFF81, 1, 0, 8'h00, 1, 1);
    idle();
    chk("rst_mid_read", rd_valid, 0);
    go(16'h0042, 1, 0, 8'h00);
    chk("boot_remapped", boot_oe, 1);
    chk("boot_addr", boot_addr, 16'h42);
    idle();
    chk("boot_remapped_din", cpu_din, 16'h31);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Address decoder and bus controller between cpu_top's external bus and the memory devices (boot ROM wrapper, WRAM, cartridge port).
- Decodes each CPU access and drives the selected device's enables.
- Holds the boot-ROM-disable latch (0xFF50) and the internal HRAM (0xFF80-0xFFFE).
- Returns read data with fixed, registered latency.

Parameters:
HRAM_DEPTH, 127, number of HRAM bytes at 0xFF80 upward; addresses at or above 0xFF80+HRAM_DEPTH are unmapped.
UNMAPPED_VAL, 8'hFF, byte returned for reads of unmapped addresses.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
cpu_addr  in  16  CPU address bus.
cpu_dout  in  8  write data from CPU.
cpu_din  out  8  read data to CPU, registered.
mem_oe  in  1  CPU read strobe, one cycle per access.
mem_wr  in  1  CPU write strobe, one cycle per access.
mem_cs  in  1  CPU bus-cycle qualifier; strobes are ignored when low.
rd_valid  out  1  one-cycle pulse: cpu_din holds the read result.
boot_oe  out  1  boot ROM output enable.
boot_addr  out  8  boot ROM address (cpu_addr[7:0]).
boot_dout  in  8  boot ROM data, valid the same cycle as boot_oe.
wram_cs  out  1  WRAM chip select.
wram_oe  out  1  WRAM read enable.
wram_wr  out  1  WRAM write enable.
wram_addr  out  13  WRAM byte address.
wram_din  out  8  WRAM write data.
wram_dout  in  8  WRAM read data, valid the same cycle as wram_oe.
cart_cs  out  1  cartridge select, for 0x0000-0x7FFF when boot ROM is not mapped, and for 0xA000-0xBFFF.
cart_dout  in  8  cartridge read data.
boot_done  out  1  boot ROM disabled (latch state).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - cpu_din = 8'h00, rd_valid = 0, boot_done = 0.
  - All device enables are 0.
  - HRAM contents are not reset.
- Access qualification:
  - An access is valid when mem_cs & (mem_oe | mem_wr).
  - If mem_oe and mem_wr are both high, the write is performed and no read occurs (rd_valid stays 0).
- Decode priority:
  1. Boot ROM: 0x0000-0x00FF while boot_done = 0.
  2. Cartridge: 0x0000-0x7FFF.
  3. Cartridge: 0xA000-0xBFFF.
  4. WRAM: 0xC000-0xDFFF, wram_addr = cpu_addr[12:0].
  5. Echo: 0xE000-0xFDFF (see the optional feature).
  6. Boot latch: 0xFF50.
  7. HRAM: 0xFF80-0xFFFE, index = cpu_addr - 0xFF80.
  8. Anything else is unmapped.
- Device enables are combinational from the decode, asserted only in the access cycle. boot_oe, wram_oe and wram_wr are gated by the matching strobe.
- Read latency:
  - Request in cycle N, cpu_din updated and rd_valid = 1 at edge N+1.
  - cpu_din holds its value until the next read completes.
  - Back-to-back reads are supported every cycle.
- Write rules:
  - Boot ROM writes are ignored.
  - HRAM writes take effect at the edge of the request cycle. A read of the same HRAM address in the next cycle returns the new value.
  - Writing any value with bit0 = 1 to 0xFF50 sets boot_done. It is sticky and cleared only by rst.
  - Reading 0xFF50 returns {7'h7F, boot_done}.
  - Writes to unmapped addresses are dropped.
- Boot handover: after boot_done rises, reads of 0x0000-0x00FF go to the cartridge starting with the next access.
- Reset mid-access: rst wins. No write is committed in that cycle, and rd_valid = 0 on the following cycle.

Optional Feature:
MEM_ECHO_EN
- Defined: 0xE000-0xFDFF mirrors WRAM, with wram_addr = cpu_addr[12:0] and full read/write.
- Undefined: that range is unmapped, reads return UNMAPPED_VAL, writes are dropped, and wram_cs stays 0.

Test Plan:
1. Reset, then read 0x0000 with boot_dout = 8'h31 -> boot_oe = 1 in the request cycle; next cycle cpu_din = 8'h31 and rd_valid = 1; cart_cs = 0.
2. Write 8'h01 to 0xFF50, then read 0x0000 with cart_dout = 8'hC3 -> boot_done = 1; cart_cs = 1; cpu_din = 8'hC3; a read of 0xFF50 returns 8'hFF.
3. Write 8'hA5 to 0xC123 -> wram_cs = 1, wram_wr = 1, wram_addr = 13'h0123, wram_din = 8'hA5. With MEM_ECHO_EN, a read of 0xE123 drives wram_addr = 13'h0123; without it, the read returns 8'hFF.
4. Write 8'h5A to 0xFFFE, then read 0xFFFE on the very next cycle -> cpu_din = 8'h5A. A read of 0xFEA0 returns 8'hFF with no device enables asserted.
5. Assert mem_oe and mem_wr together at 0xFF80 with data 8'h77 -> HRAM[0] = 8'h77 and rd_valid stays 0.
6. Set boot_done, then assert rst during a write to 0xFF81 -> boot_done = 0, cpu_din = 8'h00, and HRAM[1] is unchanged.
